i2c_txn_arbiter: RTL and testbench
==================================

# i2c_txn_arbiter

Transaction-level sequencer and two-port arbiter for the byte-level I2C SERDES driver. It takes complete register-access requests (write or read, 1 or 2 data bytes) from two requesters: port 0 is the PC wire-in path, port 1 is the periodic ADT7420 temperature poller. It grants one requester round-robin and expands the request into the START/WRITE/RESTART/READ/STOP command sequence the driver executes. It returns read data, completion and error status to the granted requester.

## Interface
- TIMEOUT_CYCLES, 200000: max clk cycles allowed between a command pulse and drv_done (1 ms at 200 MHz).
- clk  in  1  system clock (IBUFGDS oscillator output).
- reset  in  1  synchronous, active-high.
- req  in  2  per-requester level request; held until that port's done pulse.
- req_rw  in  2  per port: 1 = read, 0 = write.
- req_len2  in  2  per port: 1 = two data bytes, 0 = one.
- req_dev  in  14  {dev1[6:0], dev0[6:0]}: 7-bit slave address.
- req_reg  in  16  {reg1, reg0}: register pointer byte.
- req_wdata  in  32  {wd1, wd0}: write data; MSB byte sent first; len1 sends [7:0] only.
- grant  out  2  one-hot owner of the current transaction; 0 when idle.
- done  out  2  one-cycle completion pulse to the owner.
- err  out  1  valid with done: 1 = NACK or timeout.
- rdata  out  16  valid with done on reads; held until the next done.
- busy  out  1  transaction in progress.
- drv_cmd  out  3  0 NOP, 1 START, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 STOP, 6 RESTART.
- drv_cmd_valid  out  1  one-cycle command strobe.
- drv_tx_byte  out  8  byte for WRITE; valid with drv_cmd_valid.
- drv_done  in  1  one-cycle pulse: driver finished the last command.
- drv_rx_byte  in  8  valid with drv_done after READ_*.
- drv_nack  in  1  valid with drv_done after WRITE: slave NACKed.

## Operation
- States: IDLE, ISSUE, WAIT, ABORT, RESP.
- IDLE: if any req bit is set, select a port and latch its rw, len2, dev, reg and wdata. Set grant and busy. Step index = 0. Go to ISSUE.
- Arbitration: round-robin on last_grant. With a single request, that port wins. On a tie, the port that was not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
- Write sequence: START, WRITE {dev,0}, WRITE reg, WRITE data MSB, [WRITE data LSB if len2], STOP.
- Read sequence: START, WRITE {dev,0}, WRITE reg, RESTART, WRITE {dev,1}, [READ_ACK if len2], READ_NACK, STOP.
- ISSUE: output the step's drv_cmd and drv_tx_byte, pulse drv_cmd_valid for one cycle, clear the timeout counter, go to WAIT.
- WAIT: count cycles until drv_done.
  - On drv_done after a WRITE with drv_nack=1: set the err flag, go to ABORT.
  - On drv_done after a READ: store drv_rx_byte. len2 packs as rdata={first,second}; len1 as rdata={8'h00,byte}.
  - On drv_done after STOP: go to RESP. Otherwise step++ and go to ISSUE.
- Timeout: if the counter reaches TIMEOUT_CYCLES with no drv_done, set err and go to ABORT.
- ABORT: issue STOP, then wait for drv_done (a second timeout also ends the wait), then go to RESP.
- RESP: pulse done[owner] with err, and rdata if a read. Clear grant and busy, update last_grant, go to IDLE.
- A request still high in the cycle after done counts as a new request.
- Request inputs are sampled only at grant. Changes to them mid-transaction are ignored.
- drv_done arriving in a state other than WAIT or ABORT is ignored.

## Timing
- Reset values: grant=0, done=0, err=0, rdata=0, busy=0, drv_cmd=0, drv_cmd_valid=0, drv_tx_byte=0; state=IDLE; last_grant=1.
- A reset mid-transaction returns to IDLE in the next cycle. No STOP is issued and no done pulse is produced; the driver is reset by the same signal.
- req to grant/busy: 1 cycle.
- Grant to first drv_cmd_valid: 1 cycle.
- drv_done to the next drv_cmd_valid: 2 cycles (WAIT to ISSUE, then pulse).
- drv_done of STOP to done: 2 cycles.
- Minimum re-grant: the cycle after done, IDLE samples req and grant follows 1 cycle later.
- No command is issued while the driver owns a command. At most one drv_cmd_valid occurs per drv_done.
- Timeout counter is 18 bits wide, saturates at TIMEOUT_CYCLES, and is cleared on each command issue.

## Test plan
- Port 0 one-byte write of 0x80 to dev 0x4B reg 0x03 → commands START, WRITE 0x96, WRITE 0x03, WRITE 0x80, STOP. Then done=2'b01 with err=0.
- Port 1 two-byte read of dev 0x4B reg 0x00; driver model returns 0x0C then 0x80 → WRITE 0x96, WRITE 0x00, RESTART, WRITE 0x97, READ_ACK, READ_NACK, STOP. Then done=2'b10, rdata=0x0C80, err=0.
- Address NACK on the first WRITE → next command is STOP with no further WRITEs. Then done pulses with err=1.
- Both req high from reset, each completing → grants in order 01, 10, 01, 10. Grant is never 11.
- Driver never asserts drv_done (TIMEOUT_CYCLES=50 in the bench) → STOP is issued 51 cycles after the command, then done with err=1.
- Reset asserted in WAIT of a read → the next cycle shows all outputs at reset values and no done pulse. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin two-port I2C register-access sequencer for the byte-level SERDES driver
module i2c_txn_arbiter #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  req_rw_i,
  input  logic [1:0]  req_len2_i,
  input  logic [13:0] req_dev_i,
  input  logic [15:0] req_reg_i,
  input  logic [31:0] req_wdata_i,
  output logic [1:0]  grant_o,
  output logic [1:0]  done_o,
  output logic        err_o,
  output logic [15:0] rdata_o,
  output logic        busy_o,
  output logic [2:0]  drv_cmd_o,
  output logic        drv_cmd_valid_o,
  output logic [7:0]  drv_tx_byte_o,
  input  logic        drv_done_i,
  input  logic [7:0]  drv_rx_byte_i,
  input  logic        drv_nack_i
);
  localparam logic [2:0] C_START   = 3'd1;
  localparam logic [2:0] C_WRITE   = 3'd2;
  localparam logic [2:0] C_RACK    = 3'd3;
  localparam logic [2:0] C_RNACK   = 3'd4;
  localparam logic [2:0] C_STOP    = 3'd5;
  localparam logic [2:0] C_RESTART = 3'd6;
  localparam logic [17:0] TMO = 18'(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT, RESP} state_t;
  state_t      state_q;
  logic [2:0]  step_q;
  logic        rw_q, len2_q, err_f_q, last_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q, tx_q, tx_d;
  logic [15:0] wd_q, rd_q, rdata_q;
  logic [17:0] cnt_q, cnt_d;
  logic [1:0]  grant_q, done_q;
  logic        err_q, busy_q, valid_q;
  logic [2:0]  cmd_q, cmd_d;
  logic        sel;
  // Port 1 wins when it is the only requester or when port 0 was served last.
  assign sel   = req_i[1] & (~req_i[0] | ~last_q);
  assign cnt_d = (cnt_q == TMO) ? cnt_q : cnt_q + 18'd1;
  assign grant_o         = grant_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign rdata_o         = rdata_q;
  assign busy_o          = busy_q;
  assign drv_cmd_o       = cmd_q;
  assign drv_cmd_valid_o = valid_q;
  assign drv_tx_byte_o   = tx_q;
  // Command and byte for the current step; steps past the end of a sequence map to STOP.
  always_comb begin
    cmd_d = C_STOP;
    tx_d  = 8'h00;
    case (step_q)
      3'd0: cmd_d = C_START;
      3'd1: begin cmd_d = C_WRITE; tx_d = {dev_q, 1'b0}; end
      3'd2: begin cmd_d = C_WRITE; tx_d = reg_q; end
      3'd3: if (rw_q) cmd_d = C_RESTART; else begin cmd_d = C_WRITE; tx_d = len2_q ? wd_q[15:8] : wd_q[7:0]; end
      3'd4: if (rw_q) begin cmd_d = C_WRITE; tx_d = {dev_q, 1'b1}; end else if (len2_q) begin cmd_d = C_WRITE; tx_d = wd_q[7:0]; end
      3'd5: if (rw_q) cmd_d = len2_q ? C_RACK : C_RNACK;
      3'd6: if (rw_q && len2_q) cmd_d = C_RNACK;
      default: ;
    endcase
  end
  // Transaction FSM: grant, issue one command per driver completion, abort with STOP on NACK or timeout.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      rw_q    <= 1'b0;
      len2_q  <= 1'b0;
      err_f_q <= 1'b0;
      last_q  <= 1'b1;
      dev_q   <= 7'd0;
      reg_q   <= 8'd0;
      wd_q    <= 16'd0;
      rd_q    <= 16'd0;
      cnt_q   <= 18'd0;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= 16'd0;
      busy_q  <= 1'b0;
      cmd_q   <= 3'd0;
      valid_q <= 1'b0;
      tx_q    <= 8'd0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 2'b00;
      case (state_q)
        IDLE: if (|req_i && done_q == 2'b00) begin
          grant_q <= sel ? 2'b10 : 2'b01;
          busy_q  <= 1'b1;
          rw_q    <= req_rw_i[sel];
          len2_q  <= req_len2_i[sel];
          dev_q   <= sel ? req_dev_i[13:7] : req_dev_i[6:0];
          reg_q   <= sel ? req_reg_i[15:8] : req_reg_i[7:0];
          wd_q    <= sel ? req_wdata_i[31:16] : req_wdata_i[15:0];
          step_q  <= 3'd0;
          err_f_q <= 1'b0;
          rd_q    <= 16'd0;
          state_q <= ISSUE;
        end
        ISSUE: begin
          cmd_q   <= cmd_d;
          tx_q    <= tx_d;
          valid_q <= 1'b1;
          cnt_q   <= 18'd0;
          state_q <= WAIT;
        end
        WAIT: if (drv_done_i && cmd_q == C_STOP) state_q <= RESP;
        else if ((drv_done_i && cmd_q == C_WRITE && drv_nack_i) || (!drv_done_i && cnt_q == TMO)) begin
          err_f_q <= 1'b1;
          cmd_q   <= C_STOP;
          tx_q    <= 8'h00;
          valid_q <= 1'b1;
          cnt_q   <= 18'd0;
          state_q <= ABORT;
        end else if (drv_done_i) begin
          if (cmd_q == C_RACK || cmd_q == C_RNACK) rd_q <= len2_q ? {rd_q[7:0], drv_rx_byte_i} : {8'h00, drv_rx_byte_i};
          step_q  <= step_q + 3'd1;
          state_q <= ISSUE;
        end else cnt_q <= cnt_d;
        ABORT: if (drv_done_i || cnt_q == TMO) state_q <= RESP; else cnt_q <= cnt_d;
        RESP: begin
          done_q  <= grant_q;
          err_q   <= err_f_q;
          if (rw_q) rdata_q <= rd_q;
          last_q  <= grant_q[1];
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: directed scoreboard bench with a behavioural I2C driver model
module tb_i2c_txn_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset;
  logic [1:0]  req, req_rw, req_len2;
  logic [13:0] req_dev;
  logic [15:0] req_reg;
  logic [31:0] req_wdata;
  logic [1:0]  grant, done;
  logic        err, busy, drv_cmd_valid, drv_done, drv_nack;
  logic [15:0] rdata;
  logic [2:0]  drv_cmd;
  logic [7:0]  drv_tx_byte, drv_rx_byte;
  typedef struct packed {logic [1:0] d; logic e; logic c; logic [15:0] rd;} resp_t;
  logic [10:0] expq[$];
  resp_t       dq[$];
  logic [7:0]  rxq[$];
  logic [1:0]  gseq[$];
  int          vcyc[$];
  int tests = 0, fails = 0, cyc = 0, pend = 0, ncmd = 0, nack_at = 0;
  logic mute = 1'b0, pend_nack = 1'b0, gbad = 1'b0, saw_rack = 1'b0;
  logic [7:0] pend_rx = 8'h00;
  logic [1:0] prev_grant = 2'b00;

  i2c_txn_arbiter #(.TIMEOUT_CYCLES(50)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_rw_i(req_rw), .req_len2_i(req_len2),
    .req_dev_i(req_dev), .req_reg_i(req_reg), .req_wdata_i(req_wdata),
    .grant_o(grant), .done_o(done), .err_o(err), .rdata_o(rdata), .busy_o(busy),
    .drv_cmd_o(drv_cmd), .drv_cmd_valid_o(drv_cmd_valid), .drv_tx_byte_o(drv_tx_byte),
    .drv_done_i(drv_done), .drv_rx_byte_i(drv_rx_byte), .drv_nack_i(drv_nack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic rw, input logic l2, input logic [6:0] dev, input logic [7:0] rg, input logic [15:0] wd);
    req_rw[p] = rw;
    req_len2[p] = l2;
    req_dev[p*7 +: 7] = dev;
    req_reg[p*8 +: 8] = rg;
    req_wdata[p*16 +: 16] = wd;
  endtask

  task automatic exp_write(input logic [6:0] dev, input logic [7:0] rg, input logic [15:0] wd, input logic l2);
    expq.push_back({3'd1, 8'h00});
    expq.push_back({3'd2, dev, 1'b0});
    expq.push_back({3'd2, rg});
    if (l2) begin
      expq.push_back({3'd2, wd[15:8]});
      expq.push_back({3'd2, wd[7:0]});
    end else expq.push_back({3'd2, wd[7:0]});
    expq.push_back({3'd5, 8'h00});
  endtask

  task automatic exp_read(input logic [6:0] dev, input logic [7:0] rg, input logic l2);
    expq.push_back({3'd1, 8'h00});
    expq.push_back({3'd2, dev, 1'b0});
    expq.push_back({3'd2, rg});
    expq.push_back({3'd6, 8'h00});
    expq.push_back({3'd2, dev, 1'b1});
    if (l2) expq.push_back({3'd3, 8'h00});
    expq.push_back({3'd4, 8'h00});
    expq.push_back({3'd5, 8'h00});
  endtask

  task automatic push_resp(input logic [1:0] d, input logic e, input logic c, input logic [15:0] rd);
    dq.push_back(resp_t'({d, e, c, rd}));
  endtask

  // One cycle: driver model response, command scoreboard, completion scoreboard.
  task automatic tick();
    logic [10:0] e, o;
    resp_t r;
    @(negedge clk);
    cyc++;
    drv_done = 1'b0;
    drv_nack = 1'b0;
    if (grant === 2'b11) gbad = 1'b1;
    if (grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(grant);
    prev_grant = grant;
    if (reset) pend = 0;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drv_done = 1'b1;
        drv_nack = pend_nack;
        drv_rx_byte = pend_rx;
      end
    end
    if (drv_cmd_valid === 1'b1) begin
      ncmd++;
      vcyc.push_back(cyc);
      o = {drv_cmd, (drv_cmd == 3'd2) ? drv_tx_byte : 8'h00};
      if (drv_cmd == 3'd3) saw_rack = 1'b1;
      if (expq.size() > 0) e = expq.pop_front(); else e = 11'h7ff;
      chk("drv_cmd", 32'(o), 32'(e));
      if (!mute) begin
        pend = 3;
        pend_nack = (drv_cmd == 3'd2) && (ncmd == nack_at);
        pend_rx = 8'h00;
        if ((drv_cmd == 3'd3 || drv_cmd == 3'd4) && rxq.size() > 0) pend_rx = rxq.pop_front();
      end
    end
    if (done !== 2'b00) begin
      if (dq.size() > 0) r = dq.pop_front(); else r = '0;
      chk("done_resp", 32'({done, err, r.c ? rdata : 16'h0000}), 32'({r.d, r.e, r.c ? r.rd : 16'h0000}));
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (dq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("txn_complete", 32'(dq.size()), 32'd0);
    chk("cmds_drained", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; req = 2'b00; req_rw = 2'b00; req_len2 = 2'b00;
    req_dev = '0; req_reg = '0; req_wdata = '0;
    drv_done = 1'b0; drv_rx_byte = 8'h00; drv_nack = 1'b0;
    repeat (3) tick();
    chk("rst_ctl", 32'({grant, done, busy, err}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_drv", 32'({drv_cmd, drv_cmd_valid, drv_tx_byte}), 32'd0);
    // Both ports requesting continuously from reset: strict alternation starting at port 0.
    set_port(0, 1'b0, 1'b0, 7'h4B, 8'h03, 16'h0080);
    set_port(1, 1'b1, 1'b1, 7'h4B, 8'h00, 16'h0000);
    exp_write(7'h4B, 8'h03, 16'h0080, 1'b0); push_resp(2'b01, 1'b0, 1'b0, 16'h0);
    exp_read(7'h4B, 8'h00, 1'b1); rxq.push_back(8'h12); rxq.push_back(8'h34); push_resp(2'b10, 1'b0, 1'b1, 16'h1234);
    exp_write(7'h4B, 8'h03, 16'h0080, 1'b0); push_resp(2'b01, 1'b0, 1'b0, 16'h0);
    exp_read(7'h4B, 8'h00, 1'b1); rxq.push_back(8'h56); rxq.push_back(8'h78); push_resp(2'b10, 1'b0, 1'b1, 16'h5678);
    reset = 1'b0;
    req = 2'b11;
    run(1500);
    req = 2'b00;
    chk("rr_count", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < gseq.size() && i < 4; i++) chk("rr_order", 32'(gseq[i]), (i % 2 == 1) ? 32'd2 : 32'd1);
    repeat (3) tick();
    chk("idle_after_rr", 32'({grant, busy}), 32'd0);
    // Port 0 one-byte write with request/grant/command latency checks.
    exp_write(7'h4B, 8'h03, 16'h0080, 1'b0); push_resp(2'b01, 1'b0, 1'b0, 16'h0);
    req = 2'b01;
    tick();
    chk("req_to_grant", 32'({grant, busy}), 32'({2'b01, 1'b1}));
    tick();
    chk("grant_to_cmd", 32'(drv_cmd_valid), 32'd1);
    run(500);
    req = 2'b00;
    // Port 1 two-byte read of the temperature register.
    exp_read(7'h4B, 8'h00, 1'b1); rxq.push_back(8'h0C); rxq.push_back(8'h80); push_resp(2'b10, 1'b0, 1'b1, 16'h0C80);
    req = 2'b10;
    run(500);
    req = 2'b00;
    repeat (4) tick();
    chk("rdata_hold", 32'(rdata), 32'h0C80);
    // One-byte read packs into the low byte.
    set_port(0, 1'b1, 1'b0, 7'h48, 8'h0B, 16'h0000);
    exp_read(7'h48, 8'h0B, 1'b0); rxq.push_back(8'hCB); push_resp(2'b01, 1'b0, 1'b1, 16'h00CB);
    req = 2'b01;
    run(500);
    req = 2'b00;
    // Address NACK on the first WRITE aborts straight to STOP.
    set_port(0, 1'b0, 1'b1, 7'h4B, 8'h03, 16'hABCD);
    ncmd = 0; nack_at = 2;
    expq.push_back({3'd1, 8'h00}); expq.push_back({3'd2, 8'h96}); expq.push_back({3'd5, 8'h00});
    push_resp(2'b01, 1'b1, 1'b0, 16'h0);
    req = 2'b01;
    run(500);
    req = 2'b00;
    nack_at = 0;
    // Silent driver: STOP 51 cycles after START, then a second timeout ends the abort.
    mute = 1'b1;
    vcyc.delete();
    expq.push_back({3'd1, 8'h00}); expq.push_back({3'd5, 8'h00});
    push_resp(2'b01, 1'b1, 1'b0, 16'h0);
    req = 2'b01;
    run(400);
    req = 2'b00;
    mute = 1'b0;
    chk("timeout_gap", (vcyc.size() >= 2) ? 32'(vcyc[1] - vcyc[0]) : 32'hffffffff, 32'd51);
    repeat (3) tick();
    // Reset while waiting on a READ_ACK; no STOP and no done afterwards.
    set_port(1, 1'b1, 1'b1, 7'h4B, 8'h00, 16'h0000);
    exp_read(7'h4B, 8'h00, 1'b1); rxq.push_back(8'h0C); rxq.push_back(8'h80); push_resp(2'b10, 1'b0, 1'b1, 16'h0C80);
    saw_rack = 1'b0;
    req = 2'b10;
    n = 0;
    while (!saw_rack && n < 500) begin
      tick();
      n++;
    end
    chk("reached_read", 32'(saw_rack), 32'd1);
    reset = 1'b1;
    req = 2'b00;
    expq.delete(); dq.delete(); rxq.delete();
    tick();
    chk("mid_rst_ctl", 32'({grant, done, busy, err}), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'd0);
    chk("mid_rst_drv", 32'({drv_cmd, drv_cmd_valid, drv_tx_byte}), 32'd0);
    reset = 1'b0;
    repeat (6) tick();
    chk("post_rst_idle", 32'({grant, busy, drv_cmd_valid}), 32'd0);
    set_port(0, 1'b0, 1'b1, 7'h4B, 8'h01, 16'h1234);
    exp_write(7'h4B, 8'h01, 16'h1234, 1'b1); push_resp(2'b01, 1'b0, 1'b0, 16'h0);
    req = 2'b01;
    run(500);
    req = 2'b00;
    repeat (3) tick();
    chk("grant_never_11", 32'(gbad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
